// File: rtl/debug_unit_ctrl.sv
// Host-side debug controller: decodes UART commands, loads instruction
// memory, steps or free-runs the pipeline, and dumps registers and data
// memory back over the UART transmitter.
module debug_unit_ctrl #(
    parameter int unsigned NB_REG      = 32,
    parameter int unsigned NB_BYTE     = 8,
    parameter int unsigned NB_ADDR     = 5,
    parameter int unsigned N_REGS      = 32,
    parameter int unsigned N_MEM_WORDS = 16,
    parameter int unsigned MAX_RUN     = 1024
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [NB_BYTE-1:0] i_rx_data,
    input  logic               i_rx_valid,
    output logic [NB_BYTE-1:0] o_tx_data,
    output logic               o_tx_valid,
    input  logic               i_tx_ready,
    input  logic               i_halt,
    output logic               o_dunit_clk_en,
    output logic               o_dunit_reset_pc,
    output logic               o_dunit_w_mem,
    output logic [NB_REG-1:0]  o_dunit_addr,
    output logic [NB_REG-1:0]  o_dunit_data_if,
    input  logic [NB_REG-1:0]  i_dunit_reg,
    input  logic [NB_REG-1:0]  i_dunit_mem_data
);

    localparam logic [NB_BYTE-1:0] CmdLoad = NB_BYTE'(8'h4C);
    localparam logic [NB_BYTE-1:0] CmdStep = NB_BYTE'(8'h53);
    localparam logic [NB_BYTE-1:0] CmdRun  = NB_BYTE'(8'h43);
    localparam logic [NB_BYTE-1:0] CmdRpc  = NB_BYTE'(8'h52);
    localparam logic [NB_BYTE-1:0] AckByte = NB_BYTE'(8'h06);

    localparam int unsigned RunW  = $clog2(MAX_RUN + 1);
    localparam int unsigned DumpN = N_REGS + N_MEM_WORDS;
    localparam int unsigned DumpW = (DumpN > 1) ? $clog2(DumpN) : 1;
    localparam int unsigned BufW  = NB_REG - NB_BYTE;

    localparam logic [RunW-1:0]  RunMax   = RunW'(MAX_RUN);
    localparam logic [DumpW-1:0] DumpLast = DumpW'(DumpN - 1);
    localparam logic [DumpW-1:0] RegCount = DumpW'(N_REGS);

    typedef enum logic [3:0] {
        StIdle,
        StLoadCnt,
        StLoadByte,
        StRun,
        StStep,
        StRpc,
        StDumpSet,
        StDumpWait,
        StDumpTx,
        StAck
    } state_e;

    state_e              state_q, state_d;
    logic [NB_BYTE-1:0]  cnt_q, cnt_d;          // words to load
    logic [NB_BYTE-1:0]  idx_q, idx_d;          // word being loaded
    logic [1:0]          byte_q, byte_d;        // byte within the current word
    logic [BufW-1:0]     buf_q, buf_d;          // first three bytes of a load word
    logic                w_mem_q, w_mem_d;
    logic [NB_REG-1:0]   data_if_q, data_if_d;
    logic [NB_REG-1:0]   load_addr_q, load_addr_d;
    logic [RunW-1:0]     run_q, run_d;
    logic [DumpW-1:0]    dump_q, dump_d;        // dump word index, registers first
    logic [NB_REG-1:0]   shift_q, shift_d;      // word being serialised, MSB out

    logic [NB_REG-1:0]   load_word;
    logic                dump_is_reg;
    logic [NB_REG-1:0]   dump_addr;

    assign load_word   = {buf_q, i_rx_data};
    assign dump_is_reg = (dump_q < RegCount);

    // Address presented during a dump: register index, then data word index.
    always_comb begin
        dump_addr = '0;
        if (dump_is_reg) begin
            dump_addr = NB_REG'(NB_ADDR'(dump_q));
        end else begin
            dump_addr = NB_REG'(dump_q - RegCount);
        end
    end

    // State and datapath registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            idx_q       <= '0;
            byte_q      <= '0;
            buf_q       <= '0;
            w_mem_q     <= 1'b0;
            data_if_q   <= '0;
            load_addr_q <= '0;
            run_q       <= '0;
            dump_q      <= '0;
            shift_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            byte_q      <= byte_d;
            buf_q       <= buf_d;
            w_mem_q     <= w_mem_d;
            data_if_q   <= data_if_d;
            load_addr_q <= load_addr_d;
            run_q       <= run_d;
            dump_q      <= dump_d;
            shift_q     <= shift_d;
        end
    end

    // Next-state logic for the command FSM and its counters.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        byte_d      = byte_q;
        buf_d       = buf_q;
        w_mem_d     = 1'b0;
        data_if_d   = data_if_q;
        load_addr_d = load_addr_q;
        run_d       = run_q;
        dump_d      = dump_q;
        shift_d     = shift_q;

        unique case (state_q)
            StIdle: begin
                if (i_rx_valid) begin
                    case (i_rx_data)
                        CmdLoad: state_d = StLoadCnt;
                        CmdStep: state_d = StStep;
                        CmdRun: begin
                            state_d = StRun;
                            run_d   = '0;
                        end
                        CmdRpc:  state_d = StRpc;
                        default: state_d = StIdle;
                    endcase
                end
            end
            StLoadCnt: begin
                if (i_rx_valid) begin
                    cnt_d   = i_rx_data;
                    idx_d   = '0;
                    byte_d  = '0;
                    state_d = (i_rx_data == '0) ? StAck : StLoadByte;
                end
            end
            StLoadByte: begin
                if (i_rx_valid) begin
                    buf_d  = load_word[BufW-1:0];
                    byte_d = byte_q + 2'd1;
                    if (byte_q == 2'd3) begin
                        // Word complete: one-cycle registered write strobe.
                        w_mem_d     = 1'b1;
                        data_if_d   = load_word;
                        load_addr_d = NB_REG'({idx_q, 2'b00});
                        idx_d       = idx_q + NB_BYTE'(1);
                        if (idx_q == cnt_q - NB_BYTE'(1)) begin
                            state_d = StAck;
                        end
                    end
                end
            end
            StRun: begin
                if (i_halt || (run_q >= RunMax)) begin
                    state_d = StDumpSet;
                    dump_d  = '0;
                end else begin
                    run_d = run_q + RunW'(1);
                end
            end
            StStep: begin
                state_d = StDumpSet;
                dump_d  = '0;
            end
            StRpc: begin
                state_d = StAck;
            end
            StDumpSet: begin
                state_d = StDumpWait;
            end
            StDumpWait: begin
                // Memory read data is valid one cycle after the address.
                shift_d = dump_is_reg ? i_dunit_reg : i_dunit_mem_data;
                byte_d  = '0;
                state_d = StDumpTx;
            end
            StDumpTx: begin
                if (i_tx_ready) begin
                    shift_d = shift_q << NB_BYTE;
                    byte_d  = byte_q + 2'd1;
                    if (byte_q == 2'd3) begin
                        if (dump_q == DumpLast) begin
                            state_d = StIdle;
                        end else begin
                            dump_d  = dump_q + DumpW'(1);
                            state_d = StDumpSet;
                        end
                    end
                end
            end
            StAck: begin
                if (i_tx_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Pipeline debug-port and transmitter outputs decoded from state.
    always_comb begin
        o_dunit_clk_en   = (state_q == StStep) ||
                           ((state_q == StRun) && !i_halt && (run_q < RunMax));
        // The final write strobe lands in ACK; keep the PC held for it too.
        o_dunit_reset_pc = (state_q == StLoadCnt) || (state_q == StLoadByte) ||
                           (state_q == StRpc) || w_mem_q;
        o_dunit_w_mem    = w_mem_q;
        o_dunit_data_if  = data_if_q;
        o_dunit_addr     = ((state_q == StDumpSet) || (state_q == StDumpWait)) ?
                           dump_addr : load_addr_q;
        o_tx_valid       = (state_q == StAck) || (state_q == StDumpTx);
        o_tx_data        = '0;
        if (state_q == StAck) begin
            o_tx_data = AckByte;
        end else if (state_q == StDumpTx) begin
            o_tx_data = shift_q[NB_REG-1 -: NB_BYTE];
        end
    end

endmodule

// File: tb/tb_debug_unit_ctrl.sv
// Directed testbench for debug_unit_ctrl with a small register-file and
// data-memory model standing in for the pipeline.
module tb_debug_unit_ctrl;

    localparam int MaxRun    = 8;
    localparam int DumpBytes = (32 + 16) * 4;

    logic        clk;
    logic        i_reset;
    logic [7:0]  i_rx_data;
    logic        i_rx_valid;
    logic [7:0]  o_tx_data;
    logic        o_tx_valid;
    logic        i_tx_ready;
    logic        i_halt;
    logic        o_dunit_clk_en;
    logic        o_dunit_reset_pc;
    logic        o_dunit_w_mem;
    logic [31:0] o_dunit_addr;
    logic [31:0] o_dunit_data_if;
    logic [31:0] i_dunit_reg;
    logic [31:0] i_dunit_mem_data;

    debug_unit_ctrl #(
        .MAX_RUN(MaxRun)
    ) dut (
        .i_clk           (clk),
        .i_reset         (i_reset),
        .i_rx_data       (i_rx_data),
        .i_rx_valid      (i_rx_valid),
        .o_tx_data       (o_tx_data),
        .o_tx_valid      (o_tx_valid),
        .i_tx_ready      (i_tx_ready),
        .i_halt          (i_halt),
        .o_dunit_clk_en  (o_dunit_clk_en),
        .o_dunit_reset_pc(o_dunit_reset_pc),
        .o_dunit_w_mem   (o_dunit_w_mem),
        .o_dunit_addr    (o_dunit_addr),
        .o_dunit_data_if (o_dunit_data_if),
        .i_dunit_reg     (i_dunit_reg),
        .i_dunit_mem_data(i_dunit_mem_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pipeline model: combinational register read, registered memory read.
    logic [31:0] regs[32];
    logic [31:0] dmem[16];
    logic [31:0] mem_q;
    assign i_dunit_reg      = regs[o_dunit_addr[4:0]];
    assign i_dunit_mem_data = mem_q;
    always @(posedge clk) mem_q <= dmem[o_dunit_addr[3:0]];

    // Observation logs, filled by the monitor only.
    logic [7:0]  tx_log[$];
    logic [31:0] wm_addr[$];
    logic [31:0] wm_data[$];
    int          en_total = 0;
    int          mon_viol = 0;
    int          mon_stall = 0;
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_data = 8'h00;

    // Written by the main sequence only.
    int halt_after = -1;
    int en_base = 0;
    int total = 0;
    int bad = 0;

    always @(negedge clk) begin
        if (o_dunit_clk_en) en_total = en_total + 1;
        if (o_tx_valid && i_tx_ready) tx_log.push_back(o_tx_data);
        if (o_dunit_w_mem) begin
            wm_addr.push_back(o_dunit_addr);
            wm_data.push_back(o_dunit_data_if);
            if (!o_dunit_reset_pc) mon_viol = mon_viol + 1;
        end
        if (o_tx_valid && o_dunit_clk_en) mon_viol = mon_viol + 1;
        if (prev_stall) begin
            mon_stall = mon_stall + 1;
            if (!o_tx_valid || (o_tx_data !== prev_data)) mon_viol = mon_viol + 1;
        end
        prev_stall = o_tx_valid && !i_tx_ready;
        prev_data  = o_tx_data;
    end

    // Halt input changes just after the active edge, like the other inputs.
    always @(posedge clk) begin
        #1;
        i_halt = (halt_after >= 0) && ((en_total - en_base) >= halt_after);
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        i_rx_data  = b;
        i_rx_valid = 1'b1;
        tick();
        i_rx_valid = 1'b0;
        i_rx_data  = 8'h00;
    endtask

    task automatic wait_tx(input int n, input int budget);
        int k;
        k = 0;
        while ((tx_log.size() < n) && (k < budget)) begin
            tick();
            k++;
        end
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, "_clk_en"}, 32'(o_dunit_clk_en), 32'd0);
        check({name, "_reset_pc"}, 32'(o_dunit_reset_pc), 32'd0);
        check({name, "_w_mem"}, 32'(o_dunit_w_mem), 32'd0);
        check({name, "_addr"}, o_dunit_addr, 32'd0);
        check({name, "_data_if"}, o_dunit_data_if, 32'd0);
        check({name, "_tx_valid"}, 32'(o_tx_valid), 32'd0);
        check({name, "_tx_data"}, 32'(o_tx_data), 32'd0);
    endtask

    // Compare a full dump against the model contents, registers then memory.
    task automatic check_dump(input string name, input int base);
        int          errs;
        logic [31:0] w;
        logic [7:0]  eb;
        errs = 0;
        for (int i = 0; i < DumpBytes; i++) begin
            if (i < 128) w = regs[i / 4];
            else         w = dmem[(i - 128) / 4];
            eb = w[31 - 8 * (i % 4) -: 8];
            if (base + i >= tx_log.size()) errs++;
            else if (tx_log[base + i] !== eb) errs++;
        end
        check(name, 32'(errs), 32'd0);
    endtask

    typedef struct {
        logic [31:0] word;
        logic [31:0] addr;
    } load_t;

    typedef struct {
        logic [7:0] cmd;
        int         halt_at;
        int         exp_en;
        int         exp_tx;
    } cmd_t;

    load_t lv[2];
    cmd_t  cv[6];

    initial begin
        int tbase;
        int wbase;
        int mbase;
        int sbase;

        lv[0] = '{word: 32'h2006000B, addr: 32'h0};
        lv[1] = '{word: 32'h08000010, addr: 32'h4};

        cv[0] = '{cmd: 8'h52, halt_at: -1, exp_en: 0, exp_tx: 1};
        cv[1] = '{cmd: 8'h53, halt_at: -1, exp_en: 1, exp_tx: DumpBytes};
        cv[2] = '{cmd: 8'h43, halt_at: 7, exp_en: 7, exp_tx: DumpBytes};
        cv[3] = '{cmd: 8'h43, halt_at: -1, exp_en: MaxRun, exp_tx: DumpBytes};
        cv[4] = '{cmd: 8'h43, halt_at: 0, exp_en: 0, exp_tx: DumpBytes};
        cv[5] = '{cmd: 8'h41, halt_at: -1, exp_en: 0, exp_tx: 0};

        // State after ADDI $6,$0,11; other registers hold distinct patterns.
        for (int i = 0; i < 32; i++) regs[i] = {8'(i), 8'hA5, 8'(i * 3), 8'h5A};
        regs[0] = 32'h0;
        regs[6] = 32'd11;
        for (int i = 0; i < 16; i++) dmem[i] = 32'hD0000000 | (32'(i) * 32'h00010203);

        i_reset    = 1'b1;
        i_rx_valid = 1'b0;
        i_rx_data  = 8'h00;
        i_tx_ready = 1'b1;
        repeat (3) tick();
        check_outputs_zero("reset");
        i_reset = 1'b0;
        tick();

        // Load two words.
        tbase = tx_log.size();
        wbase = wm_addr.size();
        mbase = mon_viol;
        send_byte(8'h4C);
        check("load_rpc_cmd", 32'(o_dunit_reset_pc), 32'd1);
        send_byte(8'h02);
        check("load_rpc_cnt", 32'(o_dunit_reset_pc), 32'd1);
        for (int w = 0; w < 2; w++) begin
            for (int b = 0; b < 4; b++) begin
                send_byte(lv[w].word[31 - 8 * b -: 8]);
                check("load_rpc_byte", 32'(o_dunit_reset_pc), 32'd1);
            end
        end
        wait_tx(tbase + 1, 50);
        repeat (10) tick();
        check("load_wmem_count", 32'(wm_addr.size() - wbase), 32'd2);
        for (int w = 0; w < 2; w++) begin
            check("load_addr", wm_addr[wbase + w], lv[w].addr);
            check("load_data", wm_data[wbase + w], lv[w].word);
        end
        check("load_tx_count", 32'(tx_log.size() - tbase), 32'd1);
        check("load_ack", 32'(tx_log[tbase]), 32'h06);
        check("load_monitor", 32'(mon_viol - mbase), 32'd0);

        // Load with zero words, then prove IDLE with an 'R'.
        tbase = tx_log.size();
        wbase = wm_addr.size();
        send_byte(8'h4C);
        send_byte(8'h00);
        wait_tx(tbase + 1, 50);
        repeat (5) tick();
        check("load0_wmem", 32'(wm_addr.size() - wbase), 32'd0);
        check("load0_tx_count", 32'(tx_log.size() - tbase), 32'd1);
        check("load0_ack", 32'(tx_log[tbase]), 32'h06);
        send_byte(8'h52);
        wait_tx(tbase + 2, 50);
        repeat (5) tick();
        check("load0_idle_ack", 32'(tx_log[tbase + 1]), 32'h06);

        // Command table: step, run with halt, run to limit, halted on entry.
        for (int v = 0; v < 6; v++) begin
            halt_after = cv[v].halt_at;
            en_base    = en_total;
            tbase      = tx_log.size();
            mbase      = mon_viol;
            repeat (2) tick();
            send_byte(cv[v].cmd);
            if (cv[v].exp_tx > 0) wait_tx(tbase + cv[v].exp_tx, 2000);
            repeat (20) tick();
            check($sformatf("cmd%0d_clk_en", v), 32'(en_total - en_base), 32'(cv[v].exp_en));
            check($sformatf("cmd%0d_tx_count", v), 32'(tx_log.size() - tbase),
                  32'(cv[v].exp_tx));
            if (cv[v].exp_tx == 1) begin
                check($sformatf("cmd%0d_ack", v), 32'(tx_log[tbase]), 32'h06);
            end
            if (cv[v].exp_tx == DumpBytes) begin
                check_dump($sformatf("cmd%0d_dump", v), tbase);
            end
            check($sformatf("cmd%0d_monitor", v), 32'(mon_viol - mbase), 32'd0);
            halt_after = -1;
        end

        // Transmit backpressure in the middle of a dump.
        tbase = tx_log.size();
        mbase = mon_viol;
        sbase = mon_stall;
        send_byte(8'h53);
        wait_tx(tbase + 10, 500);
        i_tx_ready = 1'b0;
        repeat (5) tick();
        check("bp_valid_held", 32'(o_tx_valid), 32'd1);
        check("bp_no_transfer", 32'(tx_log.size() - tbase), 32'd10);
        i_tx_ready = 1'b1;
        wait_tx(tbase + DumpBytes, 2000);
        repeat (20) tick();
        check("bp_tx_count", 32'(tx_log.size() - tbase), 32'(DumpBytes));
        check_dump("bp_dump", tbase);
        check("bp_stall_seen", 32'(mon_stall - sbase > 2), 32'd1);
        check("bp_monitor", 32'(mon_viol - mbase), 32'd0);

        // Reset halfway through a load word.
        wbase = wm_addr.size();
        send_byte(8'h4C);
        send_byte(8'h01);
        send_byte(8'hAA);
        send_byte(8'hBB);
        i_reset = 1'b1;
        tick();
        check_outputs_zero("midreset");
        i_reset = 1'b0;
        tick();
        send_byte(8'hCC);
        send_byte(8'hDD);
        repeat (5) tick();
        check("midreset_wmem", 32'(wm_addr.size() - wbase), 32'd0);
        tbase = tx_log.size();
        send_byte(8'h52);
        wait_tx(tbase + 1, 50);
        repeat (5) tick();
        check("midreset_rpc_count", 32'(tx_log.size() - tbase), 32'd1);
        check("midreset_rpc_ack", 32'(tx_log[tbase]), 32'h06);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
